l2_cacheline_adaptor: RTL

- Sits directly downstream of the L2 cache datapath/control, between the L2 and the physical-memory burst interface.
- Converts a single 256-bit line request (read or write-back) into a 4-beat, 64-bit burst transaction.
- Reassembles read beats into a full line and returns one response to the L2 when the line is complete.

---
 rtl/l2_cacheline_adaptor_if.sv | 29 ++
 rtl/l2_cacheline_adaptor.sv | 108 ++++++++++
 2 files changed

// File: rtl/l2_cacheline_adaptor_if.sv
// Bus bundle between the L2 line side and the 64-bit burst memory side.
// The adaptor uses the slave view. The L2/memory environment uses the master view.
interface l2_cacheline_adaptor_if #(
  parameter int S_LINE = 256,
  parameter int S_BEAT = 64
);
  logic [S_LINE-1:0] line_i;
  logic [S_LINE-1:0] line_o;
  logic [31:0]       address_i;
  logic              read_i;
  logic              write_i;
  logic              resp_o;
  logic [S_BEAT-1:0] burst_i;
  logic [S_BEAT-1:0] burst_o;
  logic [31:0]       address_o;
  logic              read_o;
  logic              write_o;
  logic              resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/l2_cacheline_adaptor.sv
// Splits one L2 line read/write-back into a 4-beat memory burst.
// Reassembles read beats into a full line and issues a one-cycle resp_o when the line completes.
module l2_cacheline_adaptor #(
  parameter int s_offset = 5,
  parameter int s_beat   = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  l2_cacheline_adaptor_if.slave  bus
);

  localparam int s_line    = 8 * (2 ** s_offset);
  localparam int num_beats = s_line / s_beat;
  localparam int CNT_W     = $clog2(num_beats);
  localparam int BASE_W    = $clog2(s_line);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_addr;
  logic [s_line-1:0]  r_line;
  logic [CNT_W-1:0]   r_cnt;
  logic [BASE_W-1:0]  w_base;
  logic               w_lastBeat;
  logic [31:0]        w_lineAddr;

  assign w_base     = BASE_W'(r_cnt) << $clog2(s_beat);
  assign w_lastBeat = bus.resp_i && (r_cnt == CNT_W'(num_beats - 1));
  assign w_lineAddr = {bus.address_i[31:s_offset], {s_offset{1'b0}}};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_line  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          // Write-back wins when both requests are raised together.
          if (bus.write_i) begin
            r_line <= bus.line_i;
            r_addr <= w_lineAddr;
            r_cnt  <= '0;
          end else if (bus.read_i) begin
            r_addr <= w_lineAddr;
            r_cnt  <= '0;
          end
        end
        READ: begin
          if (bus.resp_i) begin
            r_line[w_base +: s_beat] <= bus.burst_i;
            r_cnt                    <= r_cnt + CNT_W'(1);
          end
        end
        WRITE: begin
          if (bus.resp_i) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.write_i)     w_next = WRITE;
        else if (bus.read_i) w_next = READ;
      end
      READ:    if (w_lastBeat) w_next = DONE;
      WRITE:   if (w_lastBeat) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are forced low for the whole reset window, including the cycle before the reset edge.
  always_comb begin
    bus.read_o    = 1'b0;
    bus.write_o   = 1'b0;
    bus.resp_o    = 1'b0;
    bus.address_o = '0;
    bus.burst_o   = '0;
    bus.line_o    = '0;
    if (rst) begin
      bus.line_o = r_line;
      case (r_state)
        READ: begin
          bus.read_o    = 1'b1;
          bus.address_o = r_addr;
        end
        WRITE: begin
          bus.write_o   = 1'b1;
          bus.address_o = r_addr;
          bus.burst_o   = r_line[w_base +: s_beat];
        end
        DONE:    bus.resp_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
